// File: rtl/gigatron_gamepad_tx.sv
// NES/Famicom controller transmitter: latch loads buttons, pulse shifts MSB first.
// Optional GAMEPAD_TX_GLITCH_FILTER_EN drops latch/pulse glitches shorter than 2 cycles.
module gigatron_gamepad_tx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  localparam int CW         = $clog2(WIDTH + 1)
) (
  input  logic             clock_50,
  input  logic             reset,
  input  logic [WIDTH-1:0] buttons,
  input  logic             latch,
  input  logic             pulse,
  output logic             data_out,
  output logic             busy,
  output logic [CW-1:0]    bit_count
);

  typedef enum logic [1:0] {
    IDLE, LOAD, SHIFT, DONE
  } state_t;

  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [SYNC_STAGES-1:0] lsync_q;
  logic [SYNC_STAGES-1:0] psync_q;
  logic                   latch_s;
  logic                   pulse_s;
  logic                   pulse_d_q;
  logic                   pulse_rise;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      lsync_q <= '0;
      psync_q <= '0;
    end else begin
      lsync_q <= {lsync_q[SYNC_STAGES-2:0], latch};
      psync_q <= {psync_q[SYNC_STAGES-2:0], pulse};
    end
  end

`ifdef GAMEPAD_TX_GLITCH_FILTER_EN
  // Accept a level only once two adjacent stages agree on it.
  logic latch_f_q;
  logic pulse_f_q;

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      latch_f_q <= 1'b0;
      pulse_f_q <= 1'b0;
    end else begin
      if (lsync_q[SYNC_STAGES-1] == lsync_q[SYNC_STAGES-2])
        latch_f_q <= lsync_q[SYNC_STAGES-1];
      if (psync_q[SYNC_STAGES-1] == psync_q[SYNC_STAGES-2])
        pulse_f_q <= psync_q[SYNC_STAGES-1];
    end
  end

  assign latch_s = latch_f_q;
  assign pulse_s = pulse_f_q;
`else
  assign latch_s = lsync_q[SYNC_STAGES-1];
  assign pulse_s = psync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) pulse_d_q <= 1'b0;
    else       pulse_d_q <= pulse_s;
  end

  assign pulse_rise = pulse_s & ~pulse_d_q;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    // Latch overrides every state, including a pending pulse edge.
    if (latch_s) begin
      state_d = LOAD;
      shreg_d = buttons;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: shreg_d = '1;
        LOAD: state_d = SHIFT;
        SHIFT: begin
          if (pulse_rise) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b1};
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) state_d = DONE;
          end
        end
        DONE: begin
          shreg_d = '1;
          cnt_d   = CNT_MAX;
        end
      endcase
    end
    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '1;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign data_out  = shreg_q[WIDTH-1];
  assign busy      = busy_q;
  assign bit_count = cnt_q;

endmodule
